// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA job path.
// Pure definitions; no logic, latency or flow control.
package rsa_pkg;

  localparam int RSA_W = 6;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_CHECK,
    ST_START,
    ST_WAIT,
    ST_OUT
  } rsa_job_state_t;

  localparam logic [1:0] RSA_OK          = 2'b00;
  localparam logic [1:0] RSA_ERR_N       = 2'b01;
  localparam logic [1:0] RSA_ERR_RANGE   = 2'b10;
  localparam logic [1:0] RSA_ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/rsa_job_ctrl.sv
// Collects key/data/n beats, range-checks them, launches rsa_top and returns result+status.
// Latency: start 2 cycles after 3rd beat; result 1 cycle after done (or TIMEOUT+1 after start).
// Backpressure: in_ready only while loading; result held in OUT until out_ready.
module rsa_job_ctrl
  import rsa_pkg::*;
#(
  parameter int W       = RSA_W,
  parameter int TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_word,
  output logic [W-1:0] rsa_key,
  output logic [W-1:0] rsa_data,
  output logic [W-1:0] rsa_n,
  output logic         rsa_start,
  input  logic         rsa_done,
  input  logic [W-1:0] rsa_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic [1:0]   out_err,
  output logic         busy
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // Last WAIT cycle: the count that is about to become TIMEOUT.
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

  rsa_job_state_t state_q, state_d;
  logic [1:0]     idx_q, idx_d;
  logic [CW-1:0]  wdog_q, wdog_d;
  logic [W-1:0]   res_d;
  logic [1:0]     err_d;
  logic           beat;

  assign in_ready  = (state_q == ST_LOAD) && !rst;
  assign busy      = (state_q != ST_LOAD) && !rst;
  assign rsa_start = (state_q == ST_START) && !rst;
  assign out_valid = (state_q == ST_OUT) && !rst;
  assign beat      = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wdog_d  = wdog_q;
    res_d   = out_result;
    err_d   = out_err;
    case (state_q)
      ST_LOAD: begin
        if (beat) begin
          if (idx_q == 2'd2) begin
            idx_d   = 2'd0;
            state_d = ST_CHECK;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      ST_CHECK: begin
        if (rsa_n < W'(2)) begin
          err_d   = RSA_ERR_N;
          res_d   = '0;
          state_d = ST_OUT;
        end else if (rsa_data >= rsa_n) begin
          err_d   = RSA_ERR_RANGE;
          res_d   = '0;
          state_d = ST_OUT;
        end else begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        wdog_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        wdog_d = wdog_q + CW'(1);
        // done beats the watchdog when both land in the same cycle
        if (rsa_done) begin
          res_d   = rsa_result;
          err_d   = RSA_OK;
          state_d = ST_OUT;
        end else if (wdog_q == WD_LAST) begin
          res_d   = '0;
          err_d   = RSA_ERR_TIMEOUT;
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_ready) state_d = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_LOAD;
      idx_q      <= '0;
      wdog_q     <= '0;
      out_result <= '0;
      out_err    <= '0;
      rsa_key    <= '0;
      rsa_data   <= '0;
      rsa_n      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wdog_q     <= wdog_d;
      out_result <= res_d;
      out_err    <= err_d;
      // Operands move only on load beats, so they stay put through START/WAIT.
      if (beat) begin
        case (idx_q)
          2'd0:    rsa_key  <= in_word;
          2'd1:    rsa_data <= in_word;
          default: rsa_n    <= in_word;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rsa_job_ctrl.sv
// Bench for rsa_job_ctrl: two instances (default watchdog, TIMEOUT=15) each driving a behavioural rsa_top model.
module tb_rsa_job_ctrl;
  import rsa_pkg::*;

  localparam int W = RSA_W;

  logic         clk;
  logic         rst;
  logic [1:0]   in_valid, in_ready, rsa_start, rsa_done, out_valid, out_ready, busy;
  logic [W-1:0] in_word    [2];
  logic [W-1:0] rsa_key    [2];
  logic [W-1:0] rsa_data   [2];
  logic [W-1:0] rsa_n      [2];
  logic [W-1:0] rsa_result [2];
  logic [W-1:0] out_result [2];
  logic [1:0]   out_err    [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nstart [2] = '{0, 0};
  int start_cyc [2] = '{0, 0};

  int           mlat  [2];
  bit           men   [2];
  int           mcnt  [2];
  bit           mpend [2];
  logic [W-1:0] mres  [2];

  rsa_job_ctrl #(.W(W)) u_dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_word(in_word[0]),
    .rsa_key(rsa_key[0]), .rsa_data(rsa_data[0]), .rsa_n(rsa_n[0]),
    .rsa_start(rsa_start[0]), .rsa_done(rsa_done[0]), .rsa_result(rsa_result[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_result(out_result[0]), .out_err(out_err[0]), .busy(busy[0])
  );

  rsa_job_ctrl #(.W(W), .TIMEOUT(15)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_word(in_word[1]),
    .rsa_key(rsa_key[1]), .rsa_data(rsa_data[1]), .rsa_n(rsa_n[1]),
    .rsa_start(rsa_start[1]), .rsa_done(rsa_done[1]), .rsa_result(rsa_result[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_result(out_result[1]), .out_err(out_err[1]), .busy(busy[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int modexp(input int key, input int base, input int n);
    int r;
    if (n == 0) return 0;
    r = 1 % n;
    for (int i = 0; i < key; i++) r = (r * base) % n;
    return r;
  endfunction

  // Behavioural rsa_top: done pulses mlat cycles after start; deliberately not reset so late dones can be seen.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      rsa_done[k] <= 1'b0;
      if (rsa_start[k]) begin
        mpend[k] <= 1'b1;
        mcnt[k]  <= 1;
        mres[k]  <= W'(modexp(int'(rsa_key[k]), int'(rsa_data[k]), int'(rsa_n[k])));
      end else if (mpend[k]) begin
        mcnt[k] <= mcnt[k] + 1;
        if (mcnt[k] >= mlat[k] - 1) begin
          mpend[k] <= 1'b0;
          if (men[k]) begin
            rsa_done[k]   <= 1'b1;
            rsa_result[k] <= mres[k];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rsa_start[k]) begin
        nstart[k]    <= nstart[k] + 1;
        start_cyc[k] <= cyc;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_all_zero(input int k);
    chk("rst_in_ready", int'(in_ready[k]), 0);
    chk("rst_busy", int'(busy[k]), 0);
    chk("rst_rsa_start", int'(rsa_start[k]), 0);
    chk("rst_out_valid", int'(out_valid[k]), 0);
    chk("rst_rsa_key", int'(rsa_key[k]), 0);
    chk("rst_rsa_data", int'(rsa_data[k]), 0);
    chk("rst_rsa_n", int'(rsa_n[k]), 0);
    chk("rst_out_result", int'(out_result[k]), 0);
    chk("rst_out_err", int'(out_err[k]), 0);
  endtask

  // Returns at the negedge after the third beat, with in_valid dropped.
  task automatic send_job(input int k, input logic [W-1:0] a, input logic [W-1:0] d,
                          input logic [W-1:0] n, input bit gaps, output int t3);
    logic [W-1:0] w [3];
    w[0] = a; w[1] = d; w[2] = n;
    t3 = -1;
    for (int bi = 0; bi < 3; bi++) begin
      bit got = 1'b0;
      for (int g = 0; g < 200 && !got; g++) begin
        @(negedge clk);
        if (gaps && $urandom_range(0, 1) == 1) begin
          in_valid[k] = 1'b0;
        end else begin
          in_valid[k] = 1'b1;
          in_word[k]  = w[bi];
          if (in_ready[k]) begin
            got = 1'b1;
            t3  = cyc;
          end
        end
      end
      if (!got) chk("beat_accept_timeout", 0, 1);
    end
    @(negedge clk);
    in_valid[k] = 1'b0;
  endtask

  task automatic wait_out(input int k, output int tout);
    bit got = 1'b0;
    tout = -1;
    for (int g = 0; g < 3000 && !got; g++) begin
      @(negedge clk);
      if (out_valid[k]) begin
        got  = 1'b1;
        tout = cyc;
      end
    end
    if (!got) chk("out_valid_timeout", 0, 1);
  endtask

  // exp_dly: cycles from rsa_start to out_valid.
  task automatic do_job(input int k, input logic [W-1:0] a, input logic [W-1:0] d,
                        input logic [W-1:0] n, input bit gaps, input logic [1:0] eerr,
                        input logic [W-1:0] eres, input bit launch, input int exp_dly);
    int t3, tout, n0;
    n0 = nstart[k];
    send_job(k, a, d, n, gaps, t3);
    chk("check_busy", int'(busy[k]), 1);
    chk("check_in_ready", int'(in_ready[k]), 0);
    wait_out(k, tout);
    chk("out_err", int'(out_err[k]), int'(eerr));
    chk("out_result", int'(out_result[k]), int'(eres));
    chk("rsa_key", int'(rsa_key[k]), int'(a));
    chk("rsa_data", int'(rsa_data[k]), int'(d));
    chk("rsa_n", int'(rsa_n[k]), int'(n));
    if (launch) begin
      chk("start_count", nstart[k] - n0, 1);
      chk("start_cycle", start_cyc[k], t3 + 2);
      chk("out_latency", tout - start_cyc[k], exp_dly);
    end else begin
      chk("no_start", nstart[k] - n0, 0);
      chk("err_latency", tout - t3, 2);
    end
    @(negedge clk);
    chk("ready_after_out", int'(in_ready[k]), 1);
    chk("valid_after_out", int'(out_valid[k]), 0);
  endtask

  typedef struct {
    logic [W-1:0] key;
    logic [W-1:0] data;
    logic [W-1:0] n;
    logic [1:0]   err;
    logic [W-1:0] res;
    bit           launch;
  } vec_t;

  vec_t vt [11];

  initial begin
    int t3, tout, s, n0;
    bit seen;
    vt[0]  = '{6'd7,  6'd2,  6'd33, 2'b00, 6'd29, 1'b1};
    vt[1]  = '{6'd5,  6'd1,  6'd1,  2'b01, 6'd0,  1'b0};
    vt[2]  = '{6'd5,  6'd40, 6'd33, 2'b10, 6'd0,  1'b0};
    vt[3]  = '{6'd3,  6'd4,  6'd33, 2'b00, 6'd31, 1'b1};
    vt[4]  = '{6'd0,  6'd0,  6'd0,  2'b01, 6'd0,  1'b0};
    vt[5]  = '{6'd9,  6'd33, 6'd33, 2'b10, 6'd0,  1'b0};
    vt[6]  = '{6'd9,  6'd32, 6'd33, 2'b00, 6'd32, 1'b1};
    vt[7]  = '{6'd5,  6'd1,  6'd2,  2'b00, 6'd1,  1'b1};
    vt[8]  = '{6'd0,  6'd5,  6'd7,  2'b00, 6'd1,  1'b1};
    vt[9]  = '{6'd5,  6'd40, 6'd1,  2'b01, 6'd0,  1'b0};
    vt[10] = '{6'd63, 6'd62, 6'd63, 2'b00, 6'd62, 1'b1};

    rst        = 1'b1;
    in_valid   = 2'b00;
    out_ready  = 2'b11;
    in_word[0] = '0;
    in_word[1] = '0;
    mlat[0] = 20; mlat[1] = 20;
    men[0]  = 1'b1; men[1] = 1'b1;

    repeat (3) @(negedge clk);
    chk_all_zero(0);
    chk_all_zero(1);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready0", int'(in_ready[0]), 1);
    chk("post_rst_ready1", int'(in_ready[1]), 1);

    for (int i = 0; i < 11; i++)
      do_job(0, vt[i].key, vt[i].data, vt[i].n, (i % 2) == 1,
             vt[i].err, vt[i].res, vt[i].launch, 21);

    // Output backpressure: result held for 5 cycles, then released.
    out_ready[0] = 1'b0;
    send_job(0, 6'd7, 6'd2, 6'd33, 1'b1, t3);
    wait_out(0, tout);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", int'(out_valid[0]), 1);
      chk("bp_out_result", int'(out_result[0]), 29);
      chk("bp_out_err", int'(out_err[0]), 0);
      chk("bp_in_ready", int'(in_ready[0]), 0);
      chk("bp_busy", int'(busy[0]), 1);
      @(negedge clk);
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", int'(in_ready[0]), 1);
    chk("bp_release_valid", int'(out_valid[0]), 0);
    chk("bp_release_busy", int'(busy[0]), 0);

    // Reset 10 cycles into WAIT; the model's late done must be ignored.
    n0 = nstart[0];
    send_job(0, 6'd7, 6'd2, 6'd33, 1'b0, t3);
    for (int g = 0; g < 50 && nstart[0] == n0; g++) @(negedge clk);
    chk("rw_started", nstart[0] - n0, 1);
    s = start_cyc[0];
    for (int g = 0; g < 50 && cyc < s + 10; g++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero(0);
    rst  = 1'b0;
    seen = 1'b0;
    for (int g = 0; g < 50 && cyc < s + 24; g++) begin
      @(negedge clk);
      seen |= out_valid[0];
    end
    chk("late_done_ignored", int'(seen), 0);
    chk("rw_ready", int'(in_ready[0]), 1);
    do_job(0, 6'd3, 6'd4, 6'd33, 1'b0, 2'b00, 6'd31, 1'b1, 21);

    // Watchdog on the TIMEOUT=15 instance.
    men[1] = 1'b0;
    do_job(1, 6'd7, 6'd2, 6'd33, 1'b0, 2'b11, 6'd0, 1'b1, 16);
    men[1]  = 1'b1;
    mlat[1] = 15;
    do_job(1, 6'd7, 6'd2, 6'd33, 1'b0, 2'b00, 6'd29, 1'b1, 16);
    mlat[1] = 16;
    do_job(1, 6'd3, 6'd4, 6'd33, 1'b0, 2'b11, 6'd0, 1'b1, 16);
    mlat[1] = 10;
    do_job(1, 6'd3, 6'd4, 6'd33, 1'b1, 2'b00, 6'd31, 1'b1, 11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rsa_job_ctrl.md
# rsa_job_ctrl

Job controller that sits directly upstream of `rsa_top`. It collects one RSA job (key, data, modulus) as three words over a valid/ready stream and range-checks the operands. It then launches `rsa_top` with a one-cycle `start` pulse, waits for `done` under a watchdog, and returns the result with a status code over a second valid/ready stream. It replaces direct pin-driving of `rsa_top` operands and gives host-side logic a flow-controlled job interface.

## Interface
- `W`, 6: operand/result width; matches `rsa_top`.
- `TIMEOUT`, 1023: max cycles to wait for `rsa_done` after `rsa_start`; counter width `$clog2(TIMEOUT+1)`.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: synchronous reset, active-high.
- `in_valid` in 1: input word valid.
- `in_ready` out 1: controller accepts a word this cycle.
- `in_word` in W: operand word; beat order per job is key, data, n.
- `rsa_key`, `rsa_data`, `rsa_n` out W each: operands to `rsa_top`; registered.
- `rsa_start` out 1: one-cycle launch pulse to `rsa_top`.
- `rsa_done` in 1: completion from `rsa_top`.
- `rsa_result` in W: result from `rsa_top`; valid while `rsa_done`=1.
- `out_valid` out 1: result/status valid.
- `out_ready` in 1: consumer accepts result.
- `out_result` out W: modular exponentiation result; 0 on any error.
- `out_err` out 2: status code. 00 = ok, 01 = bad modulus (n<2), 10 = data ≥ n, 11 = timeout.
- `busy` out 1: high in every state except LOAD.

## Operation
- FSM states: LOAD, CHECK, START, WAIT, OUT. Reset state is LOAD with beat index 0.
- **LOAD**
  - `in_ready` = 1 (forced 0 while `rst`=1).
  - Each beat with `in_valid && in_ready` stores `in_word` by beat index: 0 → key, 1 → data, 2 → n. Index then increments.
  - Accepting beat 2 moves to CHECK and clears the index.
- **CHECK** (1 cycle)
  - n < 2 → `out_err`=01, `out_result`=0, go to OUT.
  - Otherwise, data ≥ n (unsigned) → `out_err`=10, `out_result`=0, go to OUT.
  - Otherwise go to START.
  - The n check takes priority over the data check.
- **START**: `rsa_start`=1 for exactly this cycle; clear watchdog; go to WAIT.
- **WAIT**
  - Watchdog increments every cycle.
  - First cycle with `rsa_done`=1 → capture `rsa_result`, set `out_err`=00, go to OUT.
  - Watchdog reaching TIMEOUT with `rsa_done`=0 → `out_err`=11, `out_result`=0, go to OUT.
  - If `rsa_done` is high in the same cycle the watchdog hits TIMEOUT, `rsa_done` wins.
- **OUT**: `out_valid`=1; `out_result` and `out_err` held stable until `out_ready`=1; then return to LOAD.
- `rsa_done` outside WAIT is ignored.
- `rsa_key`, `rsa_data`, `rsa_n` change only on LOAD beats, so they are stable from START through WAIT.
- `in_word` values are used as-is; there is no modular reduction of key.

## Timing
- Reset values:
  - All outputs 0: `in_ready`, `rsa_start`, `rsa_key`, `rsa_data`, `rsa_n`, `out_valid`, `out_result`, `out_err`, `busy`.
  - Internal state: FSM = LOAD, beat index 0, watchdog 0.
- First cycle after `rst` deasserts: `in_ready`=1.
- Third beat accepted at cycle t → CHECK at t+1 → `rsa_start` high at t+2.
- Operand error path: third beat at t → `out_valid`=1 at t+2.
- `rsa_done` sampled high at cycle d → `out_valid`=1 at d+1.
- `rsa_start` at s with no done → `out_valid` (err 11) at s+TIMEOUT+1.
- `out_valid && out_ready` at cycle u → `in_ready`=1 at u+1. Back-to-back jobs have a minimum 1-cycle bubble.
- `rst` mid-job (any state) returns to LOAD the next cycle and discards partial operands and any pending result. `rsa_top` shares `rst`.

## Structure
- Shared package `rsa_pkg`:
  - Default `W`.
  - FSM state enum `rsa_job_state_t`.
  - Status constants `RSA_OK`, `RSA_ERR_N`, `RSA_ERR_RANGE`, `RSA_ERR_TIMEOUT`.
- No sub-module. Beat index, watchdog, and FSM are inline in one module.

## Test plan
All scenarios use a behavioural `rsa_top` model that asserts `done` 20 cycles after `start` unless stated otherwise.
- Nominal: beats 7, 2, 33; `out_ready`=1 → one `rsa_start` pulse, then `out_result`=29, `out_err`=00, `out_valid` one cycle after `done`.
- Operand errors:
  - Beats 5, 1, 1 → no `rsa_start`; `out_err`=01 and `out_result`=0 two cycles after beat 3.
  - Beats 5, 40, 33 → `out_err`=10.
- Timeout: TIMEOUT=15, model never asserts `done` → `out_err`=11, `out_valid` 16 cycles after `rsa_start`; the next job then runs normally.
- Backpressure:
  - `in_valid` toggled randomly → operands latched correctly.
  - `out_ready` held low 5 cycles → `out_result` and `out_err` stable, `in_ready`=0, `busy`=1.
  - Release → `in_ready`=1 the next cycle.
- Reset mid-WAIT: `rst` pulsed 10 cycles after `rsa_start` → all outputs 0; a late `done` is ignored; the next job (3, 4, 33 → 64 mod 33 = 31) returns 31.
